// File: rtl/spi_pkg.sv
// Shared definitions for the SPI blocks: controller state encodings.
package spi_pkg;

    typedef logic [2:0] spi_state_t;

    localparam spi_state_t ST_IDLE  = 3'd0;
    localparam spi_state_t ST_SETUP = 3'd1;
    localparam spi_state_t ST_XFER  = 3'd2;
    localparam spi_state_t ST_HOLD  = 3'd3;
    localparam spi_state_t ST_GAP   = 3'd4;

endpackage

// File: rtl/spi_xfer_ctrl.sv
// SPI transaction sequencer: chip-select framing with setup/hold/gap timing
// around a word-counted TX/RX stream exchange with an SPI master.
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready high
// SETUP | cs asserted, waiting cs_setup+1 cycles before data
// XFER  | TX words forwarded until len sent; wait for len RX words and idle bus
// HOLD  | cs still asserted for cs_hold+1 cycles after the last word
// GAP   | cs released for cs_gap+1 cycles before the next command
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 8,
    parameter int NUM_CS          = 4,
    parameter int LEN_WIDTH       = 8,
    parameter int DELAY_WIDTH     = 8,
    localparam int CS_WIDTH       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [CS_WIDTH-1:0]        cmd_cs,
    input  logic [LEN_WIDTH-1:0]       cmd_len,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0] m_spi_tdata,
    output logic                       m_spi_tvalid,
    input  logic                       m_spi_tready,
    input  logic [AXIS_DATA_WIDTH-1:0] s_spi_tdata,
    input  logic                       s_spi_tvalid,
    output logic                       s_spi_tready,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    input  logic                       spi_bus_active,
    input  logic [DELAY_WIDTH-1:0]     cs_setup,
    input  logic [DELAY_WIDTH-1:0]     cs_hold,
    input  logic [DELAY_WIDTH-1:0]     cs_gap,
    output logic [NUM_CS-1:0]          cs_n,
    output logic                       busy,
    output logic                       done
);

    spi_state_t             state;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   tx_cnt;
    logic [LEN_WIDTH-1:0]   rx_cnt;
    logic [DELAY_WIDTH-1:0] dly_cnt;
    logic [DELAY_WIDTH-1:0] hold_q;
    logic [DELAY_WIDTH-1:0] gap_q;
    logic [NUM_CS-1:0]      cs_sel_n;
    logic                   cmd_fire;
    logic                   tx_gate;
    logic                   tx_fire;
    logic                   rx_fire;
    logic                   dly_zero;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign dly_zero  = (dly_cnt == '0);

    // rst also closes the gate so no TX word slips out during the reset cycle
    assign tx_gate       = (state == ST_XFER) && (tx_cnt < len_q) && !rst;
    assign m_spi_tdata   = s_axis_tdata;
    assign m_spi_tvalid  = s_axis_tvalid && tx_gate;
    assign s_axis_tready = m_spi_tready && tx_gate;
    assign tx_fire       = m_spi_tvalid && m_spi_tready;

    assign m_axis_tdata  = s_spi_tdata;
    assign m_axis_tvalid = s_spi_tvalid;
    assign s_spi_tready  = m_axis_tready;
    assign rx_fire       = s_spi_tvalid && m_axis_tready;

    // An out-of-range index decodes to no select at all
    always_comb begin
        cs_sel_n = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            cs_sel_n[i] = (int'(cmd_cs) != i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cs_n    <= '1;
            tx_cnt  <= '0;
            rx_cnt  <= '0;
            dly_cnt <= '0;
            done    <= 1'b0;
            len_q   <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        len_q  <= cmd_len;
                        hold_q <= cs_hold;
                        gap_q  <= cs_gap;
                        tx_cnt <= '0;
                        rx_cnt <= '0;
                        if (cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state   <= ST_SETUP;
                            cs_n    <= cs_sel_n;
                            dly_cnt <= cs_setup;
                        end
                    end
                end
                ST_SETUP: begin
                    if (dly_zero) state <= ST_XFER;
                    else          dly_cnt <= dly_cnt - DELAY_WIDTH'(1);
                end
                ST_XFER: begin
                    if (tx_fire) tx_cnt <= tx_cnt + LEN_WIDTH'(1);
                    if (rx_fire) rx_cnt <= rx_cnt + LEN_WIDTH'(1);
                    // Registered rx_cnt keeps a cycle between the last RX word and HOLD
                    if ((rx_cnt == len_q) && !spi_bus_active) begin
                        state   <= ST_HOLD;
                        dly_cnt <= hold_q;
                    end
                end
                ST_HOLD: begin
                    if (dly_zero) begin
                        state   <= ST_GAP;
                        cs_n    <= '1;
                        dly_cnt <= gap_q;
                    end else begin
                        dly_cnt <= dly_cnt - DELAY_WIDTH'(1);
                    end
                end
                ST_GAP: begin
                    if (dly_zero) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end else begin
                        dly_cnt <= dly_cnt - DELAY_WIDTH'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cs_n  <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: phase/duration model checked every cycle, loopback
// SPI master and client stream models, plus directed literal expectations.
`timescale 1ns/1ps
module tb_spi_xfer_ctrl;

    localparam int NCS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_cs = '0;
    logic [7:0] cmd_len = '0;
    logic [7:0] s_axis_tdata = '0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic [7:0] m_spi_tdata;
    logic       m_spi_tvalid;
    logic       m_spi_tready = 1'b1;
    logic [7:0] s_spi_tdata = '0;
    logic       s_spi_tvalid = 1'b0;
    logic       s_spi_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b1;
    logic       spi_bus_active = 1'b0;
    logic [7:0] cs_setup = '0;
    logic [7:0] cs_hold = '0;
    logic [7:0] cs_gap = '0;
    logic [3:0] cs_n;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    spi_xfer_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_cs(cmd_cs), .cmd_len(cmd_len),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_spi_tdata(m_spi_tdata), .m_spi_tvalid(m_spi_tvalid), .m_spi_tready(m_spi_tready),
        .s_spi_tdata(s_spi_tdata), .s_spi_tvalid(s_spi_tvalid), .s_spi_tready(s_spi_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .spi_bus_active(spi_bus_active),
        .cs_setup(cs_setup), .cs_hold(cs_hold), .cs_gap(cs_gap),
        .cs_n(cs_n), .busy(busy), .done(done)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Client TX source, loopback SPI master, client RX sink
    logic [7:0] cl_q[$];
    logic [7:0] lb_q[$];
    logic [7:0] rx_got[$];
    int         n_fwd = 0;

    always @(negedge clk) begin
        if (rst) begin
            lb_q.delete();
        end else begin
            if (s_spi_tvalid && s_spi_tready) void'(lb_q.pop_front());
            if (m_spi_tvalid && m_spi_tready) begin
                lb_q.push_back(m_spi_tdata);
                n_fwd++;
            end
        end
        if (s_axis_tvalid && s_axis_tready) void'(cl_q.pop_front());
        if (m_axis_tvalid && m_axis_tready) rx_got.push_back(m_axis_tdata);
    end

    always @(posedge clk) begin
        #2;
        s_spi_tvalid   = (lb_q.size() > 0);
        s_spi_tdata    = (lb_q.size() > 0) ? lb_q[0] : 8'h00;
        spi_bus_active = (lb_q.size() > 0);
        s_axis_tvalid  = (cl_q.size() > 0);
        s_axis_tdata   = (cl_q.size() > 0) ? cl_q[0] : 8'h00;
    end

    // Model: the transaction is a sequence of phases whose lengths follow
    // from the latched timing fields and the observed word traffic.
    typedef enum int {P_IDLE, P_SETUP, P_XFER, P_HOLD, P_GAP} phase_t;
    phase_t ph = P_IDLE;
    int  left = 0, m_len = 0, m_cs = 0, m_hold = 0, m_gap = 0, m_tx = 0, m_rx = 0;
    bit  m_done = 1'b0;
    bit  chk_en = 1'b0;
    int  mon_cyc = 0, mon_low = 0, mon_gap = 0, mon_done = 0, first_low = -1, first_tv = -1;

    always @(negedge clk) begin
        logic [3:0] exp_cs;
        bit gate;
        if (chk_en) begin
            exp_cs = 4'hF;
            if ((ph inside {P_SETUP, P_XFER, P_HOLD}) && m_cs < NCS) exp_cs[m_cs] = 1'b0;
            gate = (ph == P_XFER) && (m_tx < m_len) && !rst;
            check("cs_n", cs_n, exp_cs);
            check("busy", busy, ph != P_IDLE);
            check("done", done, m_done);
            check("cmd_ready", cmd_ready, ph == P_IDLE);
            check("m_spi_tvalid", m_spi_tvalid, s_axis_tvalid && gate);
            check("s_axis_tready", s_axis_tready, m_spi_tready && gate);
            if (m_spi_tvalid) check("m_spi_tdata", m_spi_tdata, s_axis_tdata);
            check("m_axis_tvalid", m_axis_tvalid, s_spi_tvalid);
            if (m_axis_tvalid) check("m_axis_tdata", m_axis_tdata, s_spi_tdata);
            check("s_spi_tready", s_spi_tready, m_axis_tready);
            check("cs_one_low", $countones(~cs_n) <= 1, 1);
            mon_cyc++;
            if (busy && cs_n != 4'hF) begin
                mon_low++;
                if (first_low < 0) first_low = mon_cyc;
            end
            if (busy && cs_n == 4'hF) mon_gap++;
            if (done) mon_done++;
            if (m_spi_tvalid && first_tv < 0) first_tv = mon_cyc;
        end
        if (rst) begin
            ph = P_IDLE; m_done = 1'b0; m_tx = 0; m_rx = 0; left = 0;
        end else begin
            m_done = 1'b0;
            case (ph)
                P_IDLE: if (cmd_valid) begin
                    if (cmd_len == 0) m_done = 1'b1;
                    else begin
                        ph = P_SETUP; left = cs_setup; m_cs = cmd_cs; m_len = cmd_len;
                        m_hold = cs_hold; m_gap = cs_gap; m_tx = 0; m_rx = 0;
                    end
                end
                P_SETUP: if (left == 0) ph = P_XFER; else left--;
                P_XFER: begin
                    if (m_rx == m_len && !spi_bus_active) begin ph = P_HOLD; left = m_hold; end
                    if ((m_tx < m_len) && s_axis_tvalid && m_spi_tready) m_tx++;
                    if (s_spi_tvalid && m_axis_tready) m_rx++;
                end
                P_HOLD: if (left == 0) begin ph = P_GAP; left = m_gap; end else left--;
                P_GAP:  if (left == 0) begin ph = P_IDLE; m_done = 1'b1; end else left--;
                default: ph = P_IDLE;
            endcase
        end
    end

    task automatic clr_mon();
        @(posedge clk); #1;
        mon_cyc = 0; mon_low = 0; mon_gap = 0; mon_done = 0; first_low = -1; first_tv = -1;
        rx_got.delete();
    endtask

    task automatic send_cmd(input int cs, input int len, input int su, input int hd, input int gp);
        bit ok = 1'b0;
        @(posedge clk); #1;
        cmd_cs = 2'(cs); cmd_len = 8'(len); cs_setup = 8'(su); cs_hold = 8'(hd); cs_gap = 8'(gp);
        cmd_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        check("cmd_accepted", ok, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        // Scramble config inputs; only the latched copies may matter now
        cmd_cs = 2'($urandom); cmd_len = 8'($urandom);
        cs_setup = 8'($urandom); cs_hold = 8'($urandom); cs_gap = 8'($urandom);
    endtask

    task automatic wait_done(input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        check("done_seen", ok, 1);
        repeat (2) @(posedge clk);
    endtask

    task automatic check_rx(input string name, input logic [7:0] exp[$]);
        int bad = 0;
        if (rx_got.size() != exp.size()) bad++;
        else for (int i = 0; i < exp.size(); i++) if (rx_got[i] !== exp[i]) bad++;
        check({name, "_rx_size"}, rx_got.size(), exp.size());
        check({name, "_rx_bad_words"}, bad, 0);
    endtask

    initial begin
        int f0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_cs_n", cs_n, 4'hF);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reference transaction with loopback
        clr_mon();
        cl_q = '{8'hA5, 8'h3C, 8'hFF};
        f0 = n_fwd;
        send_cmd(2, 3, 2, 1, 4);
        wait_done(200);
        check("t1_cs_to_tvalid", first_tv - first_low, 3);
        check("t1_low_cycles", mon_low, 10);
        check("t1_gap_cycles", mon_gap, 5);
        check("t1_done_count", mon_done, 1);
        check("t1_fwd", n_fwd - f0, 3);
        check_rx("t1", '{8'hA5, 8'h3C, 8'hFF});

        // Zero-length command
        clr_mon();
        send_cmd(1, 0, 5, 5, 5);
        @(negedge clk);
        check("t2_done_next", done, 1);
        check("t2_ready_next", cmd_ready, 1);
        @(negedge clk);
        check("t2_done_single", done, 0);
        check("t2_cs_idle", cs_n, 4'hF);
        check("t2_never_busy", mon_low + mon_gap, 0);

        // Zero timing, back-to-back cs0 then cs1
        clr_mon();
        cl_q = '{8'h11, 8'h22};
        send_cmd(0, 1, 0, 0, 0);
        wait_done(100);
        send_cmd(1, 1, 0, 0, 0);
        wait_done(100);
        check("t3_low_cycles", mon_low, 10);
        check("t3_gap_cycles", mon_gap, 2);
        check("t3_done_count", mon_done, 2);
        check_rx("t3", '{8'h11, 8'h22});

        // Client offers more words than the command length
        clr_mon();
        cl_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        f0 = n_fwd;
        send_cmd(1, 2, 1, 0, 0);
        wait_done(100);
        check("t4_fwd", n_fwd - f0, 2);
        check("t4_left_in_client", cl_q.size(), 3);
        check_rx("t4", '{8'h01, 8'h02});
        @(posedge clk); #1;
        cl_q.delete();

        // RX sink stalled during XFER
        clr_mon();
        m_axis_tready = 1'b0;
        cl_q = '{8'h5A, 8'hC3};
        send_cmd(3, 2, 1, 0, 0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t5_still_busy", busy, 1);
        check("t5_cs_low", cs_n, 4'h7);
        check("t5_no_rx_yet", rx_got.size(), 0);
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
        wait_done(100);
        check_rx("t5", '{8'h5A, 8'hC3});

        // Reset in the middle of XFER
        clr_mon();
        cl_q = '{8'h10, 8'h20};
        send_cmd(1, 4, 0, 0, 0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t6_in_xfer_cs", cs_n, 4'hD);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_cs_released", cs_n, 4'hF);
        check("t6_busy_low", busy, 0);
        f0 = n_fwd;
        @(posedge clk); #1;
        cl_q = '{8'h30, 8'h40};
        repeat (6) @(posedge clk);
        check("t6_no_fwd_after_rst", n_fwd - f0, 0);
        check("t6_no_done", mon_done, 0);
        @(posedge clk); #1;
        cl_q = '{8'h77};
        rx_got.delete();
        send_cmd(1, 1, 0, 0, 0);
        wait_done(100);
        check_rx("t6", '{8'h77});

        // Maximum length completes without count wrap
        clr_mon();
        for (int i = 0; i < 255; i++) cl_q.push_back(8'(i));
        f0 = n_fwd;
        send_cmd(2, 255, 0, 0, 0);
        wait_done(2000);
        check("t7_fwd", n_fwd - f0, 255);
        check("t7_rx_count", rx_got.size(), 255);
        check("t7_last_word", (rx_got.size() == 255) ? rx_got[254] : 8'h00, 8'hFE);
        check("t7_done_count", mon_done, 1);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
        $fatal(1);
    end

endmodule

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 8, meaning the SPI word width carried on all streams.
REQ-002 SHALL have parameter NUM_CS, default 4, meaning the number of chip-select outputs.
REQ-003 SHALL have parameter LEN_WIDTH, default 8, meaning the width of the word-count field.
REQ-004 SHALL have parameter DELAY_WIDTH, default 8, meaning the width of the CS timing fields.
REQ-005 SHALL have the following ports, listed as name, direction, width, meaning:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high; clock clk.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_cs  in  clog2(NUM_CS)  target chip-select index.
- cmd_len  in  LEN_WIDTH  words in the transaction.
- s_axis_tdata / tvalid / tready  in / in / out  AXIS_DATA_WIDTH / 1 / 1  TX words from the client.
- m_spi_tdata / tvalid / tready  out / out / in  AXIS_DATA_WIDTH / 1 / 1  TX words to the SPI master.
- s_spi_tdata / tvalid / tready  in / in / out  AXIS_DATA_WIDTH / 1 / 1  RX words from the SPI master.
- m_axis_tdata / tvalid / tready  out / out / in  AXIS_DATA_WIDTH / 1 / 1  RX words to the client.
- spi_bus_active  in  1  SPI master busy flag.
- cs_setup / cs_hold / cs_gap  in  DELAY_WIDTH each  CS timing, in clk cycles.
- cs_n  out  NUM_CS  active-low chip selects.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse at transaction end.

Function
REQ-006 SHALL implement the states IDLE, SETUP, XFER, HOLD and GAP.
REQ-007 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&&cmd_ready it SHALL latch cmd_cs, cmd_len, cs_setup, cs_hold and cs_gap.
REQ-008 SHALL, on acceptance of a command with cmd_len=0, stay in IDLE, leave every cs_n bit high, and pulse done on the next cycle.
REQ-009 SHALL, on acceptance of a command with cmd_len>0, enter SETUP with cs_n[cs]=0 registered on the following edge.
REQ-010 SHALL load a delay counter with the latched field (cs_setup, cs_hold or cs_gap) on entry to SETUP, HOLD and GAP respectively, decrement it each cycle, and exit when it equals 0, so each of these states lasts field+1 cycles.
REQ-011 SHALL move from SETUP to XFER on counter expiry.
REQ-012 SHALL, in XFER, connect the TX path combinationally: m_spi_tdata=s_axis_tdata, m_spi_tvalid=s_axis_tvalid&&gate, s_axis_tready=m_spi_tready&&gate, where gate=(state==XFER)&&(tx_cnt<len).
REQ-013 SHALL increment tx_cnt on each m_spi handshake.
REQ-014 SHALL connect the RX path combinationally in every state (m_axis_tdata=s_spi_tdata, m_axis_tvalid=s_spi_tvalid, s_spi_tready=m_axis_tready) and increment rx_cnt on each handshake while in XFER.
REQ-015 SHALL move from XFER to HOLD when rx_cnt==len && !spi_bus_active; the transition SHALL be evaluated with the registered rx_cnt, so at least one cycle separates the last RX handshake from entry to HOLD.
REQ-016 SHALL, in HOLD, keep cs_n[cs] low.
REQ-017 SHALL move from HOLD to GAP on counter expiry; cs_n SHALL be all ones during GAP.
REQ-018 SHALL move from GAP to IDLE on counter expiry and pulse done for exactly 1 cycle, on the first IDLE cycle.
REQ-019 SHALL register cs_n; at most one cs_n bit SHALL be low at any time.
REQ-020 SHALL treat a latched cmd_cs>=NUM_CS as executing the transaction with no cs_n bit asserted.
REQ-021 SHALL ignore config-input changes during a transaction, since only the latched values are used.
REQ-022 SHALL size tx_cnt and rx_cnt at LEN_WIDTH bits; a count of 2^LEN_WIDTH-1 SHALL complete without wrap.

Reset
REQ-023 SHALL, on rst, set: state=IDLE; cs_n=all ones; tx_cnt=0; rx_cnt=0; delay counter=0; done=0; busy=0.
REQ-024 SHALL, on rst asserted mid-transaction, raise cs_n on the next edge, discard the command without a done pulse, and forward no further TX words.

Structure
REQ-025 SHALL place the state encodings (IDLE=0, SETUP=1, XFER=2, HOLD=3, GAP=4; 3 bits) in the shared SPI package used by the SPI blocks.
REQ-026 SHALL use a single flat module with no sub-modules; the delay counter is inline.

Verification
REQ-027 SHALL cover: cmd cs=2, len=3, setup=2, hold=1, gap=4, TX A5,3C,FF with loopback -> cs_n[2] low 3 cycles before the first m_spi_tvalid, 3 RX words A5,3C,FF, HOLD 2 cycles, GAP 5 cycles with cs_n=4'hF, then one done pulse.
REQ-028 SHALL cover: len=0 -> cs_n stays 4'hF, done pulses 1 cycle after acceptance, cmd_ready high again next cycle.
REQ-029 SHALL cover: setup=hold=gap=0, len=1 -> SETUP, HOLD and GAP each last 1 cycle; back-to-back commands to cs 0 then cs 1 never assert both cs_n bits.
REQ-030 SHALL cover: client offers 5 TX words with len=2 -> exactly 2 forwarded, s_axis_tready low for the remainder.
REQ-031 SHALL cover: m_axis_tready held low 20 cycles during XFER -> state remains XFER, cs_n[cs] stays low until the RX words drain.
REQ-032 SHALL cover: rst asserted in XFER -> cs_n=4'hF next edge, busy=0, no done, and a new command completes normally.
